// File: rtl/reg_scoreboard_if.sv
// Issue and writeback handshake bundle between decode, the scoreboard and writeback.
// master = decode/writeback side, slave = scoreboard.
interface reg_scoreboard_if #(
  parameter int AW = 5
);
  logic          issue_valid;
  logic          issue_ready;
  logic [AW-1:0] issue_rs1;
  logic [AW-1:0] issue_rs2;
  logic          issue_use_rs1;
  logic          issue_use_rs2;
  logic [AW-1:0] issue_rd;
  logic          issue_rd_we;
  logic          wb_valid;
  logic [AW-1:0] wb_rd;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
           issue_rd, issue_rd_we, wb_valid, wb_rd,
    input  issue_ready
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
           issue_rd, issue_rd_we, wb_valid, wb_rd,
    output issue_ready
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard; SCOREBOARD_BYPASS_EN lets a source issue alongside its last writeback.
// Latency: issue_ready is combinational (zero cycles); counters update at the next edge.
// Backpressure: issue_ready drops on source hazard, saturated destination counter, or flush.
module reg_scoreboard #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  reg_scoreboard_if.slave  sb,
  output logic [NREGS-1:0] busy_mask,
  output logic [6:0]       inflight,
  output logic             err_underflow
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt [NREGS];
  logic [CNT_W-1:0] cnt_rs1, cnt_rs2, cnt_rd, cnt_wb;
  logic             byp_rs1, byp_rs2;
  logic             src_haz, dst_haz, fire, inc, dec, underflow;

  assign cnt_rs1 = cnt[sb.issue_rs1];
  assign cnt_rs2 = cnt[sb.issue_rs2];
  assign cnt_rd  = cnt[sb.issue_rd];
  assign cnt_wb  = cnt[sb.wb_rd];

`ifdef SCOREBOARD_BYPASS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  // Last outstanding write retires this cycle; the forwarding path supplies the value.
  assign byp_rs1 = sb.wb_valid && (sb.wb_rd == sb.issue_rs1) && (cnt_rs1 == CNT_ONE);
  assign byp_rs2 = sb.wb_valid && (sb.wb_rd == sb.issue_rs2) && (cnt_rs2 == CNT_ONE);
`else
  assign byp_rs1 = 1'b0;
  assign byp_rs2 = 1'b0;
`endif

  always_comb begin
    src_haz = 1'b0;
    dst_haz = 1'b0;
    if (sb.issue_use_rs1 && (sb.issue_rs1 != '0) && (cnt_rs1 != '0) && !byp_rs1)
      src_haz = 1'b1;
    if (sb.issue_use_rs2 && (sb.issue_rs2 != '0) && (cnt_rs2 != '0) && !byp_rs2)
      src_haz = 1'b1;
    if (sb.issue_rd_we && (sb.issue_rd != '0) && (cnt_rd == CNT_MAX))
      dst_haz = 1'b1;
  end

  assign sb.issue_ready = !flush && !src_haz && !dst_haz;
  assign fire           = sb.issue_valid && sb.issue_ready;
  assign inc            = fire && sb.issue_rd_we && (sb.issue_rd != '0);
  assign dec            = sb.wb_valid && (sb.wb_rd != '0) && (cnt_wb != '0);
  assign underflow      = !flush && sb.wb_valid && (sb.wb_rd != '0) && (cnt_wb == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
      inflight      <= '0;
      err_underflow <= 1'b0;
    end else begin
      // Register 0 never holds a pending write, so its counter stays at reset value.
      for (int r = 1; r < NREGS; r++) begin
        if (flush)
          cnt[r] <= '0;
        else if (inc && (sb.issue_rd == AW'(r)) && !(dec && (sb.wb_rd == AW'(r))))
          cnt[r] <= cnt[r] + CNT_W'(1);
        else if (dec && (sb.wb_rd == AW'(r)) && !(inc && (sb.issue_rd == AW'(r))))
          cnt[r] <= cnt[r] - CNT_W'(1);
      end
      if (flush)
        inflight <= '0;
      else
        inflight <= inflight + {6'b0, inc} - {6'b0, dec};
      if (underflow)
        err_underflow <= 1'b1;
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int r = 1; r < NREGS; r++) busy_mask[r] = (cnt[r] != '0);
  end
endmodule
